// File: rtl/led_blinker_multi.sv
// led_blinker_multi: multi-channel LED blinker, shared tick prescaler, per-channel OFF/ON/BLINK/BURST modes
// Ports: CLK50/RESET clock and sync active-high reset; CFG_VALID/CFG_READY/CFG_CH/CFG_MODE/CFG_HALF/CFG_COUNT
// runtime channel configuration write; LED per-channel drive; BUSY per-channel burst-in-progress; TICK time-base strobe.
// Optional macro LED_BLINKER_DIM_EN adds CFG_DUTY and a 16-step PWM brightness gate on LED.
module led_blinker_multi #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int CHANNELS = 4,
  parameter int HALF_W   = 16,
  parameter int CNT_W    = 8
) (
  input  logic                                                CLK50,
  input  logic                                                RESET,
  input  logic                                                CFG_VALID,
  output logic                                                CFG_READY,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0]    CFG_CH,
  input  logic [1:0]                                          CFG_MODE,
  input  logic [HALF_W-1:0]                                   CFG_HALF,
  input  logic [CNT_W-1:0]                                    CFG_COUNT,
`ifdef LED_BLINKER_DIM_EN
  input  logic [3:0]                                          CFG_DUTY,
`endif
  output logic [CHANNELS-1:0]                                 LED,
  output logic [CHANNELS-1:0]                                 BUSY,
  output logic                                                TICK
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(DIV - 1);
  typedef enum logic [1:0] {OFF, ON, BLINK, BURST} mode_t;
  logic [PW-1:0] pre_q, pre_d;
  logic tick_q, tick_d, ready_q, ready_d;
  mode_t mode_q [CHANNELS];
  mode_t mode_d [CHANNELS];
  logic [HALF_W-1:0] half_q [CHANNELS];
  logic [HALF_W-1:0] half_d [CHANNELS];
  logic [HALF_W-1:0] phase_q [CHANNELS];
  logic [HALF_W-1:0] phase_d [CHANNELS];
  logic [CNT_W-1:0] rem_q [CHANNELS];
  logic [CNT_W-1:0] rem_d [CHANNELS];
  logic [CHANNELS-1:0] led_q, led_d, busy_q, busy_d, on;
  always_comb begin
    pre_d = (pre_q == TC) ? '0 : pre_q + PW'(1);
    tick_d = (pre_q == TC);
    ready_d = 1'b1;
    led_d = led_q;
    busy_d = busy_q;
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      phase_d[i] = phase_q[i];
      rem_d[i] = rem_q[i];
      if (CFG_VALID && ready_q && int'(CFG_CH) == i) begin
        // a zero-length burst is indistinguishable from OFF, so store it as OFF
        mode_d[i] = (mode_t'(CFG_MODE) == BURST && CFG_COUNT == '0) ? OFF : mode_t'(CFG_MODE);
        half_d[i] = CFG_HALF;
        rem_d[i] = CFG_COUNT;
        phase_d[i] = '0;
        led_d[i] = (mode_d[i] != OFF);
        busy_d[i] = (mode_d[i] == BURST);
      end else if (tick_q && (mode_q[i] == BLINK || mode_q[i] == BURST)) begin
        // a stored half-period of 0 behaves as 1
        if (phase_q[i] == ((half_q[i] == '0) ? '0 : half_q[i] - HALF_W'(1))) begin
          phase_d[i] = '0;
          led_d[i] = !led_q[i];
          if (mode_q[i] == BURST && led_q[i]) begin
            rem_d[i] = rem_q[i] - CNT_W'(1);
            if (rem_q[i] == CNT_W'(1)) begin
              mode_d[i] = OFF;
              busy_d[i] = 1'b0;
            end
          end
        end else begin
          phase_d[i] = phase_q[i] + HALF_W'(1);
        end
      end
    end
  end
  always_ff @(posedge CLK50) begin
    if (RESET) begin
      pre_q <= '0;
      tick_q <= 1'b0;
      ready_q <= 1'b0;
      led_q <= '0;
      busy_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= OFF;
        half_q[i] <= HALF_W'(1);
        phase_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      pre_q <= pre_d;
      tick_q <= tick_d;
      ready_q <= ready_d;
      led_q <= led_d;
      busy_q <= busy_d;
      mode_q <= mode_d;
      half_q <= half_d;
      phase_q <= phase_d;
      rem_q <= rem_d;
    end
  end
`ifdef LED_BLINKER_DIM_EN
  logic [3:0] pwm_q, pwm_d;
  logic [3:0] duty_q [CHANNELS];
  logic [3:0] duty_d [CHANNELS];
  always_comb begin
    pwm_d = pwm_q + 4'd1;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_d[i] = (CFG_VALID && ready_q && int'(CFG_CH) == i) ? CFG_DUTY : duty_q[i];
      on[i] = (pwm_q <= duty_q[i]);
    end
  end
  always_ff @(posedge CLK50) begin
    if (RESET) begin
      pwm_q <= '0;
      for (int i = 0; i < CHANNELS; i++) duty_q[i] <= 4'hF;
    end else begin
      pwm_q <= pwm_d;
      duty_q <= duty_d;
    end
  end
`else
  assign on = '1;
`endif
  assign LED = led_q & on;
  assign BUSY = busy_q;
  assign TICK = tick_q;
  assign CFG_READY = ready_q;
endmodule

// File: tb/tb_led_blinker_multi.sv
// tb_led_blinker_multi: directed self-checking bench for led_blinker_multi (100 Hz clock, 10 Hz tick, 3 channels)
module tb_led_blinker_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [15:0] cfg_half = '0;
  logic [7:0] cfg_count = '0;
`ifdef LED_BLINKER_DIM_EN
  logic [3:0] cfg_duty = 4'hF;
`endif
  logic cfg_ready, tick;
  logic [2:0] led, busy;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  led_blinker_multi #(
    .CLK_HZ(100), .TICK_HZ(10), .CHANNELS(3), .HALF_W(16), .CNT_W(8)
  ) dut (
    .CLK50(clk),
    .RESET(rst),
    .CFG_VALID(cfg_valid),
    .CFG_READY(cfg_ready),
    .CFG_CH(cfg_ch),
    .CFG_MODE(cfg_mode),
    .CFG_HALF(cfg_half),
    .CFG_COUNT(cfg_count),
`ifdef LED_BLINKER_DIM_EN
    .CFG_DUTY(cfg_duty),
`endif
    .LED(led),
    .BUSY(busy),
    .TICK(tick)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = tick;
    end
    if (!seen) check("tick_timeout", 32'd0, 32'd1);
  endtask
  task automatic post_tick();
    wait_tick();
    step();
  endtask
  task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [15:0] h, input logic [7:0] c);
    cfg_valid = 1'b1;
    cfg_ch = ch;
    cfg_mode = mode;
    cfg_half = h;
    cfg_count = c;
    step();
    cfg_valid = 1'b0;
  endtask
  logic [2:0] burst_led [5] = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
  logic [2:0] burst_busy [5] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
  initial begin
    repeat (3) begin
      step();
      check("rst_led", led, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", cfg_ready, 0);
      check("rst_tick", tick, 0);
    end
    rst = 1'b0;
    step();
    check("ready_after_rst", cfg_ready, 1);
    check("tick_edge1", tick, 0);
    for (int k = 2; k <= 30; k++) begin
      step();
      check("tick_period", tick, (k % 10 == 0));
    end
    step();
    wr(2'd1, 2'd2, 16'd2, 8'd0);
    check("blink_start", led, 3'b010);
    check("blink_busy", busy, 3'b000);
    post_tick();
    check("blink_t1", led, 3'b010);
    post_tick();
    check("blink_t2", led, 3'b000);
    post_tick();
    check("blink_t3", led, 3'b000);
    post_tick();
    check("blink_t4", led, 3'b010);
    wr(2'd1, 2'd0, 16'd1, 8'd0);
    check("blink_off", led, 3'b000);
    wr(2'd0, 2'd3, 16'd1, 8'd3);
    check("burst_led0", led, 3'b001);
    check("burst_busy0", busy, 3'b001);
    for (int k = 0; k < 5; k++) begin
      post_tick();
      check("burst_led", led, burst_led[k]);
      check("burst_busy", busy, burst_busy[k]);
    end
    repeat (2) begin
      post_tick();
      check("burst_done_led", led, 3'b000);
      check("burst_done_busy", busy, 3'b000);
    end
    wr(2'd0, 2'd3, 16'd5, 8'd0);
    check("burst0_led", led, 3'b000);
    check("burst0_busy", busy, 3'b000);
    post_tick();
    check("burst0_tick", led, 3'b000);
    wr(2'd0, 2'd2, 16'd0, 8'd0);
    check("half0_start", led, 3'b001);
    post_tick();
    check("half0_t1", led, 3'b000);
    post_tick();
    check("half0_t2", led, 3'b001);
    wr(2'd3, 2'd1, 16'd4, 8'd0);
    check("ch_oob_led", led, 3'b001);
    check("ch_oob_busy", busy, 3'b000);
    wr(2'd0, 2'd0, 16'd1, 8'd0);
    check("ch0_off", led, 3'b000);
    wr(2'd0, 2'd2, 16'd1, 8'd0);
    check("coll_pre", led, 3'b001);
    wait_tick();
    wr(2'd2, 2'd2, 16'd1, 8'd0);
    check("coll_write_wins", led, 3'b100);
    post_tick();
    check("coll_t1", led, 3'b001);
    post_tick();
    check("coll_t2", led, 3'b100);
    wr(2'd0, 2'd0, 16'd1, 8'd0);
    wr(2'd2, 2'd0, 16'd1, 8'd0);
    check("coll_off", led, 3'b000);
    wr(2'd1, 2'd3, 16'd1, 8'd5);
    check("mid_led0", led, 3'b010);
    check("mid_busy0", busy, 3'b010);
    post_tick();
    check("mid_led1", led, 3'b000);
    check("mid_busy1", busy, 3'b010);
    post_tick();
    check("mid_led2", led, 3'b010);
    wr(2'd1, 2'd0, 16'd1, 8'd0);
    check("mid_off_led", led, 3'b000);
    check("mid_off_busy", busy, 3'b000);
    wr(2'd1, 2'd3, 16'd1, 8'd5);
    check("rstmid_busy", busy, 3'b010);
    rst = 1'b1;
    step();
    check("rstmid_led", led, 0);
    check("rstmid_busy0", busy, 0);
    check("rstmid_ready", cfg_ready, 0);
    check("rstmid_tick", tick, 0);
    rst = 1'b0;
    step();
    check("rstmid_ready1", cfg_ready, 1);
    post_tick();
    check("rstmid_after_led", led, 0);
    check("rstmid_after_busy", busy, 0);
`ifdef LED_BLINKER_DIM_EN
    begin
      int hi;
      cfg_duty = 4'd3;
      wr(2'd0, 2'd1, 16'd1, 8'd0);
      hi = 0;
      repeat (16) begin
        hi += int'(led[0]);
        step();
      end
      check("dim_duty3", hi, 4);
      cfg_duty = 4'd15;
      wr(2'd0, 2'd1, 16'd1, 8'd0);
      hi = 0;
      repeat (16) begin
        hi += int'(led[0]);
        step();
      end
      check("dim_duty15", hi, 16);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/led_blinker_multi.md
Name: led_blinker_multi

Overview:
Multi-channel successor to the single-LED 50 MHz blinker. One shared prescaler produces a slow time-base tick. Each channel runs OFF, ON, BLINK or BURST mode with a programmable half-period measured in ticks. Channels are configured at runtime through a valid/ready write port. The block sits between board-level control logic and the board LED pins.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz.
TICK_HZ, 1000, time-base tick rate; prescale terminal count = CLK_HZ/TICK_HZ-1. Must divide CLK_HZ exactly.
CHANNELS, 4, number of LED channels (1..16).
HALF_W, 16, width of the half-period field, in ticks.
CNT_W, 8, width of the burst pulse-count field.

Ports:
CLK50  in  1  system clock (CLK_HZ); single clock domain.
RESET  in  1  synchronous, active-high reset.
CFG_VALID  in  1  configuration write request.
CFG_READY  out  1  block can accept a write.
CFG_CH  in  max(1,clog2(CHANNELS))  target channel index.
CFG_MODE  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
CFG_HALF  in  HALF_W  half-period in ticks.
CFG_COUNT  in  CNT_W  number of pulses in BURST mode.
LED  out  CHANNELS  LED drive, active high.
BUSY  out  CHANNELS  per-channel flag, high while a burst is in progress.
TICK  out  1  one-cycle time-base strobe.

Behaviour:
- Clocking and reset: single clock CLK50; reset is synchronous, active-high on RESET. While RESET=1 at a CLK50 edge: LED=0, BUSY=0, TICK=0, CFG_READY=0, prescaler=0, all modes=OFF, all counters=0, all half-periods=1. CFG_READY is 1 from the first edge after RESET falls.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 and then wraps. TICK is registered and high for exactly one cycle, on the cycle after the counter reaches the terminal count.
- Handshake: a write occurs when CFG_VALID&CFG_READY are both high at an edge. It takes effect at that edge, so outputs change the next cycle. CFG_READY does not depend on CFG_VALID; there is no back-pressure after reset. CFG_CH>=CHANNELS: write is accepted and ignored.
- On a write, the channel stores mode, half-period and count, clears its phase counter, and sets its state:
  - OFF: LED=0.
  - ON: LED=1.
  - BLINK: LED=1 (always starts in the on phase).
  - BURST with COUNT>0: LED=1, BUSY=1, remaining=COUNT.
  - BURST with COUNT=0: behaves as OFF, BUSY=0.
- Half-period: a stored HALF value of 0 is treated as 1.
- BLINK/BURST phase: on each TICK, if phase==HALF-1 then phase<=0 and LED toggles; otherwise phase<=phase+1. OFF and ON ignore TICK.
- BURST termination: each on→off toggle decrements remaining. When remaining reaches 0 on that toggle, mode<=OFF and BUSY<=0 in the same cycle as LED<=0. There is no trailing off phase.
- Simultaneous events: a write and a TICK on the same cycle to the same channel — the write wins and the TICK has no effect on that channel. Other channels process the TICK normally.
- Rewrite mid-burst restarts the channel from the new configuration. Reset mid-burst behaves as a full reset.
- Counter widths: phase counter is HALF_W bits, remaining is CNT_W bits. Neither counter ever wraps past its limit.

Optional Feature:
Macro: LED_BLINKER_DIM_EN.
- Defined:
  - Adds input port CFG_DUTY (4 bits), captured per channel on a write; reset value 15.
  - A free-running 4-bit counter pwm runs on CLK50.
  - LED[i] = state[i] & (pwm <= duty[i]): 16-step brightness; duty 15 = fully on, duty 0 = on 1/16 of the time.
  - BUSY, TICK and phase timing are unchanged.
- Undefined: no CFG_DUTY port; LED = state directly.

Test Plan:
1. Reset: CLK_HZ=100, TICK_HZ=10; hold RESET 3 cycles -> LED=0, BUSY=0, CFG_READY=0 during reset; CFG_READY=1 on the first edge after release; TICK pulses every 10 cycles, each 1 cycle wide.
2. BLINK: ch1, HALF=2 -> LED[1]=1 the cycle after the write; toggles on every 2nd TICK (period 40 clocks); other channels stay 0.
3. BURST: ch0, COUNT=3, HALF=1 -> BUSY[0]=1 the cycle after the write; exactly 3 high pulses, each 1 tick wide; LED[0] and BUSY[0] fall together after the 3rd pulse; mode reads as OFF afterwards (further TICKs produce no change).
4. Boundaries: BURST with COUNT=0 -> LED=0, BUSY=0. BLINK with HALF=0 -> toggles every tick. Write to CFG_CH=CHANNELS -> no channel changes.
5. Collision/restart: write ch2 BLINK HALF=1 on a TICK cycle -> phase starts at 0 and LED[2]=1, TICK ignored for ch2. Write OFF mid-burst -> LED and BUSY return to 0 the next cycle. RESET mid-burst -> all outputs return to reset values.
6. With LED_BLINKER_DIM_EN: ch0 ON with DUTY=3 -> LED[0] high exactly 4 of every 16 clocks. DUTY=15 -> LED[0] constantly high.
